// File: rtl/fetch_pc_gen_if.sv
// fetch_pc_gen_if: request/response channel between the fetch PC generator
// and the instruction cache.
//   icache_req_valid : fetch request (fetch -> cache)
//   icache_req_addr  : fetch-group base address (fetch -> cache)
//   icache_req_ready : cache accepts the request (cache -> fetch)
//   icache_rsp_valid : group data returned, in order (cache -> fetch)
//   icache_rsp_inst  : WIDTH instructions of the group (cache -> fetch)
// master = fetch side, slave = cache side.
interface fetch_pc_gen_if #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned XLEN  = 32
);
  logic                        icache_req_valid;
  logic [XLEN-1:0]             icache_req_addr;
  logic                        icache_req_ready;
  logic                        icache_rsp_valid;
  logic [WIDTH-1:0][31:0]      icache_rsp_inst;

  modport master (
    output icache_req_valid,
    output icache_req_addr,
    input  icache_req_ready,
    input  icache_rsp_valid,
    input  icache_rsp_inst
  );

  modport slave (
    input  icache_req_valid,
    input  icache_req_addr,
    output icache_req_ready,
    output icache_rsp_valid,
    output icache_rsp_inst
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch-stage PC generator and I-cache front end for a
// WIDTH-wide core. Holds the fetch PC, issues one group request at a time,
// latches the returned group and presents it slot by slot to decode while
// choosing the next fetch PC (rollback > RAS > JAL > sequential).
// Ports:
//   clock, reset        : clock, asynchronous active-low reset
//   icache              : I-cache request/response channel (master side)
//   rollback_en/_pc     : ROB redirect and its target
//   return_addr, valid_ret_addr : RAS prediction per slot
//   jal_target, jal_valid       : predecoded direct-jump target per slot
//   id_stall            : decode cannot accept the current group
//   if_valid/if_pc/if_npc/if_inst : fetch group presented to decode
module fetch_pc_gen #(
  parameter int unsigned     WIDTH    = 2,
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                        clock,
  input  logic                        reset,
  fetch_pc_gen_if.master              icache,
  input  logic                        rollback_en,
  input  logic [XLEN-1:0]             rollback_pc,
  input  logic [WIDTH-1:0][XLEN-1:0]  return_addr,
  input  logic [WIDTH-1:0]            valid_ret_addr,
  input  logic [WIDTH-1:0][XLEN-1:0]  jal_target,
  input  logic [WIDTH-1:0]            jal_valid,
  input  logic                        id_stall,
  output logic [WIDTH-1:0]            if_valid,
  output logic [WIDTH-1:0][XLEN-1:0]  if_pc,
  output logic [WIDTH-1:0][XLEN-1:0]  if_npc,
  output logic [WIDTH-1:0][31:0]      if_inst
);

  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_OUT   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam int unsigned     GRP_BYTES = 4 * WIDTH;
  localparam logic [XLEN-1:0] GRP_MASK  = XLEN'(GRP_BYTES - 1);
  localparam logic [XLEN-1:0] SLOT_MASK = XLEN'(WIDTH - 1);

  logic [1:0]             state;
  logic [XLEN-1:0]        pc;
  logic [WIDTH-1:0][31:0] inst_q;

  logic [XLEN-1:0]  base;
  logic [XLEN-1:0]  slot_idx;
  logic [WIDTH-1:0] raw_valid;
  logic [WIDTH-1:0] taken;
  logic [XLEN-1:0]  next_pc;
  logic             taken_seen;

  // Slot index of the PC inside its group; a redirect into the middle of a
  // group kills the slots before it.
  assign base     = pc & ~GRP_MASK;
  assign slot_idx = (pc >> 2) & SLOT_MASK;

  assign icache.icache_req_valid = (state == S_REQ) && !rollback_en;
  assign icache.icache_req_addr  = base;
  assign if_inst                 = inst_q;

  always_comb begin
    raw_valid  = '0;
    taken      = '0;
    if_valid   = '0;
    if_pc      = '0;
    if_npc     = '0;
    taken_seen = 1'b0;
    next_pc    = base + XLEN'(GRP_BYTES);
    for (int j = 0; j < int'(WIDTH); j++) begin
      if_pc[j]     = base + XLEN'(4 * j);
      if_npc[j]    = base + XLEN'(4 * j + 4);
      raw_valid[j] = (XLEN'(j) >= slot_idx);
      // Predictions on slots before the entry point are ignored.
      taken[j]     = raw_valid[j] && (valid_ret_addr[j] || jal_valid[j]);
      // A taken slot is itself delivered; only the slots after it are cut.
      if_valid[j]  = (state == S_OUT) && raw_valid[j] && !taken_seen && !rollback_en;
      if (taken[j] && !taken_seen) begin
        next_pc = valid_ret_addr[j] ? return_addr[j] : jal_target[j];
      end
      taken_seen = taken_seen || taken[j];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      inst_q <= '0;
    end else if (rollback_en) begin
      pc <= rollback_pc;
      // A request still in flight must have its response swallowed.
      if (state == S_DRAIN || (state == S_WAIT && !icache.icache_rsp_valid)) begin
        state <= S_DRAIN;
      end else begin
        state <= S_REQ;
      end
    end else begin
      case (state)
        S_REQ: begin
          if (icache.icache_req_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (icache.icache_rsp_valid) begin
            inst_q <= icache.icache_rsp_inst;
            state  <= S_OUT;
          end
        end
        S_OUT: begin
          if (!id_stall) begin
            pc    <= next_pc;
            state <= S_REQ;
          end
        end
        default: begin
          if (icache.icache_rsp_valid) state <= S_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
module tb_fetch_pc_gen;
  localparam int unsigned WIDTH = 2;
  localparam int unsigned XLEN  = 32;

  logic                        clock;
  logic                        reset;
  logic                        rollback_en;
  logic [XLEN-1:0]             rollback_pc;
  logic [WIDTH-1:0][XLEN-1:0]  return_addr;
  logic [WIDTH-1:0]            valid_ret_addr;
  logic [WIDTH-1:0][XLEN-1:0]  jal_target;
  logic [WIDTH-1:0]            jal_valid;
  logic                        id_stall;
  logic [WIDTH-1:0]            if_valid;
  logic [WIDTH-1:0][XLEN-1:0]  if_pc;
  logic [WIDTH-1:0][XLEN-1:0]  if_npc;
  logic [WIDTH-1:0][31:0]      if_inst;

  int checks;
  int failures;

  fetch_pc_gen_if #(.WIDTH(WIDTH), .XLEN(XLEN)) icache_bus ();

  fetch_pc_gen #(.WIDTH(WIDTH), .XLEN(XLEN), .RESET_PC(32'h100)) dut (
    .clock          (clock),
    .reset          (reset),
    .icache         (icache_bus),
    .rollback_en    (rollback_en),
    .rollback_pc    (rollback_pc),
    .return_addr    (return_addr),
    .valid_ret_addr (valid_ret_addr),
    .jal_target     (jal_target),
    .jal_valid      (jal_valid),
    .id_stall       (id_stall),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_npc         (if_npc),
    .if_inst        (if_inst)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_pred();
    return_addr    = '0;
    valid_ret_addr = '0;
    jal_target     = '0;
    jal_valid      = '0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    rollback_en = 1'b0;
    rollback_pc = '0;
    id_stall = 1'b0;
    clear_pred();
    icache_bus.icache_req_ready = 1'b1;
    icache_bus.icache_rsp_valid = 1'b0;
    icache_bus.icache_rsp_inst  = '0;

    // reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_if_valid", 64'(if_valid), 64'h0);
    chk("rst_req_valid", 64'(icache_bus.icache_req_valid), 64'h1);
    chk("rst_addr", 64'(icache_bus.icache_req_addr), 64'h100);
    chk("rst_inst", 64'(if_inst), 64'h0);
    reset = 1'b1;
    #1;

    // sequential groups 0x100, 0x108, 0x110
    chk("g0_addr", 64'(icache_bus.icache_req_addr), 64'h100);
    step();
    chk("g0_wait_noreq", 64'(icache_bus.icache_req_valid), 64'h0);
    icache_bus.icache_rsp_valid = 1'b1;
    icache_bus.icache_rsp_inst  = {32'h22222222, 32'h11111111};
    step();
    icache_bus.icache_rsp_valid = 1'b0;
    #1;
    chk("g0_if_valid", 64'(if_valid), 64'h3);
    chk("g0_if_pc", 64'(if_pc), {32'h104, 32'h100});
    chk("g0_if_npc", 64'(if_npc), {32'h108, 32'h104});
    chk("g0_if_inst", 64'(if_inst), {32'h22222222, 32'h11111111});
    step();
    chk("g1_addr", 64'(icache_bus.icache_req_addr), 64'h108);
    chk("g1_req_valid", 64'(icache_bus.icache_req_valid), 64'h1);
    step();
    icache_bus.icache_rsp_valid = 1'b1;
    icache_bus.icache_rsp_inst  = {32'h44444444, 32'h33333333};
    step();
    icache_bus.icache_rsp_valid = 1'b0;
    #1;
    chk("g1_if_valid", 64'(if_valid), 64'h3);
    chk("g1_if_pc", 64'(if_pc), {32'h10c, 32'h108});
    step();
    chk("g2_addr", 64'(icache_bus.icache_req_addr), 64'h110);

    // rollback in WAIT with response in the same cycle: response discarded
    step();
    icache_bus.icache_rsp_valid = 1'b1;
    rollback_en = 1'b1;
    rollback_pc = 32'h200;
    #1;
    chk("rbw_if_valid", 64'(if_valid), 64'h0);
    step();
    icache_bus.icache_rsp_valid = 1'b0;
    rollback_en = 1'b0;
    #1;
    chk("rbw_after_if_valid", 64'(if_valid), 64'h0);
    chk("rbw_after_addr", 64'(icache_bus.icache_req_addr), 64'h200);
    chk("rbw_after_req", 64'(icache_bus.icache_req_valid), 64'h1);

    // RAS hit in slot 0 wins over a JAL in slot 1
    step();
    icache_bus.icache_rsp_valid = 1'b1;
    step();
    icache_bus.icache_rsp_valid = 1'b0;
    valid_ret_addr = 2'b01;
    return_addr[0] = 32'h340;
    jal_valid      = 2'b10;
    jal_target[1]  = 32'h998;
    #1;
    chk("ras_if_valid", 64'(if_valid), 64'h1);
    step();
    clear_pred();
    #1;
    chk("ras_next_addr", 64'(icache_bus.icache_req_addr), 64'h340);

    // rollback in REQ suppresses the request for that cycle
    rollback_en = 1'b1;
    rollback_pc = 32'h300;
    #1;
    chk("rbr_req_valid", 64'(icache_bus.icache_req_valid), 64'h0);
    step();
    rollback_en = 1'b0;
    icache_bus.icache_req_ready = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("hold_req_valid", 64'(icache_bus.icache_req_valid), 64'h1);
      chk("hold_addr", 64'(icache_bus.icache_req_addr), 64'h300);
      if (i < 3) step();
    end
    icache_bus.icache_req_ready = 1'b1;
    step();
    icache_bus.icache_rsp_valid = 1'b1;
    icache_bus.icache_rsp_inst  = {32'h66666666, 32'h55555555};
    step();
    icache_bus.icache_rsp_valid = 1'b0;

    // JAL in slot 1 to a misaligned target
    jal_valid     = 2'b10;
    jal_target[1] = 32'h404;
    #1;
    chk("jal_if_valid", 64'(if_valid), 64'h3);
    step();
    clear_pred();
    #1;
    chk("jal_next_addr", 64'(icache_bus.icache_req_addr), 64'h400);
    step();
    icache_bus.icache_rsp_valid = 1'b1;
    step();
    icache_bus.icache_rsp_valid = 1'b0;

    // misaligned group held by id_stall; slot-0 prediction must be ignored,
    // RAS beats JAL in slot 1
    id_stall       = 1'b1;
    valid_ret_addr = 2'b11;
    return_addr    = {32'h500, 32'h777};
    jal_valid      = 2'b10;
    jal_target[1]  = 32'h600;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_if_valid", 64'(if_valid), 64'h2);
      chk("stall_if_pc1", 64'(if_pc[1]), 64'h404);
      chk("stall_no_req", 64'(icache_bus.icache_req_valid), 64'h0);
      step();
    end
    id_stall = 1'b0;
    step();
    clear_pred();
    #1;
    chk("stall_rel_req", 64'(icache_bus.icache_req_valid), 64'h1);
    chk("stall_rel_addr", 64'(icache_bus.icache_req_addr), 64'h500);

    // rollback in OUT kills if_valid combinationally
    step();
    icache_bus.icache_rsp_valid = 1'b1;
    step();
    icache_bus.icache_rsp_valid = 1'b0;
    #1;
    chk("rbo_pre_if_valid", 64'(if_valid), 64'h3);
    rollback_en = 1'b1;
    rollback_pc = 32'h600;
    #1;
    chk("rbo_if_valid", 64'(if_valid), 64'h0);
    step();
    rollback_en = 1'b0;
    #1;
    chk("rbo_addr", 64'(icache_bus.icache_req_addr), 64'h600);

    // rollback in WAIT, response two cycles later is dropped
    step();
    rollback_en = 1'b1;
    rollback_pc = 32'h80;
    #1;
    chk("drain_rb_req", 64'(icache_bus.icache_req_valid), 64'h0);
    step();
    rollback_en = 1'b0;
    #1;
    chk("drain_req", 64'(icache_bus.icache_req_valid), 64'h0);
    chk("drain_if_valid", 64'(if_valid), 64'h0);
    step();
    icache_bus.icache_rsp_valid = 1'b1;
    #1;
    chk("drain_rsp_if_valid", 64'(if_valid), 64'h0);
    chk("drain_rsp_req", 64'(icache_bus.icache_req_valid), 64'h0);
    step();
    icache_bus.icache_rsp_valid = 1'b0;
    #1;
    chk("drain_done_req", 64'(icache_bus.icache_req_valid), 64'h1);
    chk("drain_done_addr", 64'(icache_bus.icache_req_addr), 64'h80);
    chk("drain_done_if_valid", 64'(if_valid), 64'h0);

    // sequential address wraps at the top of the address space
    rollback_en = 1'b1;
    rollback_pc = 32'hFFFF_FFF8;
    step();
    rollback_en = 1'b0;
    #1;
    chk("wrap_addr", 64'(icache_bus.icache_req_addr), 64'hFFFF_FFF8);
    step();
    icache_bus.icache_rsp_valid = 1'b1;
    step();
    icache_bus.icache_rsp_valid = 1'b0;
    #1;
    chk("wrap_if_pc", 64'(if_pc), {32'hFFFF_FFFC, 32'hFFFF_FFF8});
    chk("wrap_if_npc", 64'(if_npc), {32'h0, 32'hFFFF_FFFC});
    step();
    chk("wrap_next_addr", 64'(icache_bus.icache_req_addr), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
